// File: rtl/conv_encoder_pkg.sv
// Shared constants for the K=7 rate-1/2 convolutional encoder and its output stream buffer.
package conv_encoder_pkg;

    localparam int K      = 7;
    localparam int HIST_W = K - 1;

    // Generator bit (K-1-d) selects tap x[n-d]; the MSB is the current input bit.
    localparam logic [K-1:0] G0_POLY = 7'o133;
    localparam logic [K-1:0] G1_POLY = 7'o171;

    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_FULL
    } buf_state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: output register plus skid register, with a registered s_ready.
module axis_skid_buffer
    import conv_encoder_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready
);

    buf_state_t        state;
    buf_state_t        state_next;
    logic [DATA_W-1:0] skid_data;
    logic              in_hs;
    logic              out_hs;
    logic              load_out;
    logic              load_skid;
    logic              skid_to_out;

    assign in_hs   = s_valid && s_ready;
    assign out_hs  = m_valid && m_ready;
    assign m_valid = (state != BUF_EMPTY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BUF_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        load_out    = 1'b0;
        load_skid   = 1'b0;
        skid_to_out = 1'b0;
        case (state)
            BUF_EMPTY: begin
                if (in_hs) begin
                    load_out   = 1'b1;
                    state_next = BUF_ONE;
                end
            end
            BUF_ONE: begin
                if (out_hs) begin
                    if (in_hs) begin
                        load_out = 1'b1;
                    end else begin
                        state_next = BUF_EMPTY;
                    end
                end else if (in_hs) begin
                    load_skid  = 1'b1;
                    state_next = BUF_FULL;
                end
            end
            BUF_FULL: begin
                // s_ready is low here, so only the drain of the skid entry can happen.
                if (out_hs) begin
                    skid_to_out = 1'b1;
                    state_next  = BUF_ONE;
                end
            end
            default: begin
                state_next = BUF_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data    <= '0;
            skid_data <= '0;
            s_ready   <= 1'b1;
        end else begin
            if (load_out) begin
                m_data <= s_data;
            end else if (skid_to_out) begin
                m_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= s_data;
            end
            s_ready <= (state_next != BUF_FULL);
        end
    end

endmodule

// File: rtl/conv_encoder.sv
// Rate-1/2 K=7 convolutional encoder: WIDTH input bits per beat become 2*WIDTH coded bits.
module conv_encoder
    import conv_encoder_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter bit CLEAR_ON_LAST = 1'b1
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic [WIDTH-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    output logic [2*WIDTH-1:0] m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic               m_axis_tlast
);

    logic [HIST_W-1:0]       hist;
    logic [HIST_W-1:0]       hist_next;
    logic [WIDTH+HIST_W-1:0] ext;
    logic [2*WIDTH-1:0]      coded;
    logic                    in_hs;

    assign in_hs = s_axis_tvalid && s_axis_tready;

    // Oldest history bit at ext[0], current beat on top, so x[n-d] for bit i is ext[i+HIST_W-d].
    always_comb begin
        ext = '0;
        for (int j = 0; j < HIST_W; j++) begin
            ext[j] = hist[HIST_W-1-j];
        end
        ext[WIDTH+HIST_W-1:HIST_W] = s_axis_tdata;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pair
        logic a_bit;
        logic b_bit;
        always_comb begin
            a_bit = 1'b0;
            b_bit = 1'b0;
            for (int d = 0; d < K; d++) begin
                if (G0_POLY[K-1-d]) begin
                    a_bit = a_bit ^ ext[i+HIST_W-d];
                end
                if (G1_POLY[K-1-d]) begin
                    b_bit = b_bit ^ ext[i+HIST_W-d];
                end
            end
        end
        assign coded[2*i]   = a_bit;
        assign coded[2*i+1] = b_bit;
    end

    // The newest HIST_W bits of ext also cover WIDTH < HIST_W, where older history shifts up.
    always_comb begin
        hist_next = hist;
        for (int j = 0; j < HIST_W; j++) begin
            hist_next[j] = ext[WIDTH+HIST_W-1-j];
        end
        if (CLEAR_ON_LAST && s_axis_tlast) begin
            hist_next = '0;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            hist <= '0;
        end else if (in_hs) begin
            hist <= hist_next;
        end
    end

    axis_skid_buffer #(
        .DATA_W (2*WIDTH + 1)
    ) u_skid (
        .clk     (aclk),
        .rst_n   (aresetn),
        .s_data  ({s_axis_tlast, coded}),
        .s_valid (s_axis_tvalid),
        .s_ready (s_axis_tready),
        .m_data  ({m_axis_tlast, m_axis_tdata}),
        .m_valid (m_axis_tvalid),
        .m_ready (m_axis_tready)
    );

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2 convolutional encoder for the transmit chain. Industry-standard K=7 code, generators g0=133 (octal) and g1=171 (octal).
- Sits directly downstream of the scrambler and consumes its AXI-Stream output: WIDTH scrambled bits per beat in, 2*WIDTH coded bits per beat out.
- Full throughput. Registered ready via a skid buffer, so the scrambler's combinational ready path is broken at this stage.

Parameters:
- WIDTH, 32, input data bits per beat. Output is 2*WIDTH. Legal range is WIDTH >= 1.
- CLEAR_ON_LAST, 1, when 1 the encoder history is zeroed after each beat carrying tlast, so every frame starts from the all-zero state.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- s_axis_tdata  in  WIDTH  scrambled bits; bit 0 is earliest in time.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready; driven directly from a register.
- s_axis_tlast  in  1  last beat of frame.
- m_axis_tdata  out  2*WIDTH  coded bits: [2i]=A_i, [2i+1]=B_i.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  tlast of the beat that produced this output.

Behaviour:
- Reset: asynchronous assert, synchronous deassert handled externally. During reset:
  - m_axis_tdata=0, m_axis_tvalid=0, m_axis_tlast=0.
  - s_axis_tready=1.
  - Encoder history hist[5:0]=0 and skid register empty.
- Encoding:
  - Serial bit sequence x[n]; bit i of beat k is x[k*WIDTH+i].
  - hist[0]=x[n-1] … hist[5]=x[n-6].
  - A_n = x[n]^x[n-2]^x[n-3]^x[n-5]^x[n-6]
  - B_n = x[n]^x[n-1]^x[n-2]^x[n-3]^x[n-6]
  - All WIDTH bit pairs are computed combinationally per beat. For i<6, taps reach into hist.
- History update: on an input handshake, hist takes the last 6 bits of the beat, newest in hist[0].
  - When WIDTH<6, shift in WIDTH bits and keep the older ones.
  - If s_axis_tlast=1 and CLEAR_ON_LAST=1, hist is set to 0 instead.
- Latency: 1 cycle from input handshake to m_axis_tvalid=1 with the encoded beat.
- Handshake (2-entry buffer: output register plus skid register):
  - Input handshake = s_axis_tvalid && s_axis_tready.
  - s_axis_tready <= ~(skid holds data after this cycle).
  - Output register empty, or being consumed this cycle: a new beat loads the output register directly.
  - Output register full and stalled (m_axis_tvalid && !m_axis_tready): a new beat goes to the skid register and s_axis_tready drops next cycle.
  - On output handshake with skid full: skid moves to the output register and s_axis_tready rises next cycle.
  - Simultaneous input and output handshake with skid empty: output register reloads, m_axis_tvalid stays 1.
  - No beat is ever dropped, duplicated or reordered. tdata and tlast travel together.
- AXI rules:
  - m_axis_tdata and m_axis_tlast stay stable while m_axis_tvalid && !m_axis_tready.
  - m_axis_tvalid never depends combinationally on m_axis_tready.
- Reset mid-frame: all buffered beats are discarded, hist returns to 0, and the next frame encodes from the zero state.

Decomposition:
- Shared package holds:
  - G0_POLY=7'o133 and G1_POLY=7'o171.
  - Constraint length K=7 and HIST_W=K-1.
- The encoder stays parametric on these constants.
- One sub-module, axis_skid_buffer (parameter DATA_W; carries tdata+tlast), holds the two-register handshake logic. It is reusable elsewhere in the chain.
- The encoder core (hist register plus generate loop over bit pairs) stays in conv_encoder.

Test Plan (WIDTH=8, CLEAR_ON_LAST=1 unless noted):
- Impulse: after reset, 0x01 with tlast=0, m_axis_tready=1 -> next cycle m_axis_tdata=0x34FB, m_axis_tvalid=1.
- History across beats: 0x80 (tlast=0) then 0x00 -> outputs 0xC000 then 0x0D3E.
- Clear on last: 0x80 with tlast=1 then 0x00 -> outputs 0xC000 (tlast=1) then 0x0000. With CLEAR_ON_LAST=0, the second output is 0x0D3E.
- Backpressure: tvalid held, m_axis_tready=0 for 5 cycles:
  - s_axis_tready falls after 2 accepted beats.
  - Output holds the first beat unchanged.
  - After release, beats emerge in order with no loss. Random ready gaps over 1000 beats match the reference model.
- Back-to-back: continuous valid/ready for 100 beats -> 100 outputs on 100 consecutive cycles after 1 cycle of latency; s_axis_tready stays 1.
- Reset mid-frame: assert aresetn=0 with both buffers full -> m_axis_tvalid=0 immediately. After release, 0x01 -> 0x34FB.
